// File: rtl/regfile_writeback_if.sv
// Writeback request and register-file write-port bundle for regfile_writeback.
//
// Purpose:
//   Groups the two handshaked paths that pass through the writeback block:
//   the incoming writeback request (valid/ready, rd, data) and the outgoing
//   register-file write port (we/ready, address, data).
//
// Signals:
//   wb_valid  request valid            (master -> slave)
//   wb_ready  request accepted         (slave  -> master)
//   wb_rd     destination register     (master -> slave)
//   wb_data   value to write           (master -> slave)
//   rf_we     write-port enable        (slave  -> master)
//   rf_waddr  write-port address       (slave  -> master)
//   rf_wdata  write-port data          (slave  -> master)
//   rf_ready  register file accepts    (master -> slave)
//
// Modports:
//   slave   the writeback block itself
//   master  the surrounding pipeline / register file side
interface regfile_writeback_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb_valid;
  logic            wb_ready;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            rf_ready;

  modport slave (
    input  wb_valid, wb_rd, wb_data, rf_ready,
    output wb_ready, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output wb_valid, wb_rd, wb_data, rf_ready,
    input  wb_ready, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: write side of the architectural register file.
//
// Purpose:
//   Accepts writeback requests over a valid/ready handshake, holds them in a
//   small in-order queue and presents the head entry on the register file's
//   single write port. A pending-write vector lets decode spot RAW hazards
//   against writes that have been accepted but not yet committed.
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_n    asynchronous reset, active-low
//   bus      regfile_writeback_if.slave: writeback request in, write port out
//   pending  bit r set while any queued write targets register r
//   count    number of occupied queue entries (0..DEPTH)
module regfile_writeback #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_writeback_if.slave         bus,
  output logic [NREG-1:0]            pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW  = $clog2(NREG);
  localparam int AWQ = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
  localparam logic [AWQ-1:0] ONE_PTR  = AWQ'(1);

  logic [AWQ-1:0]  head;
  logic [AWQ-1:0]  tail;
  logic [AW-1:0]   ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;

  logic push;
  logic pop;

  // Ready is derived from registered occupancy only, so a full queue cannot
  // take a new request in the same cycle it frees an entry.
  assign bus.wb_ready = (count < FULL_CNT);

  // The head entry is always on the write port whenever the queue is not
  // empty; an empty queue drives a quiet, all-zero port.
  assign bus.rf_we    = (count != '0);
  assign bus.rf_waddr = bus.rf_we ? ent_rd[head]   : '0;
  assign bus.rf_wdata = bus.rf_we ? ent_data[head] : '0;

  // Writes to x0 finish their handshake but are dropped here, so they never
  // occupy an entry or reach the write port.
  assign push = bus.wb_valid && bus.wb_ready && (bus.wb_rd != '0);
  assign pop  = bus.rf_we && bus.rf_ready;

  // Queue storage, pointers and occupancy. Pointers wrap naturally because
  // DEPTH is a power of two; count tells full apart from empty. Reset wipes
  // every entry so nothing queued before reset is ever issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_rd[e]   <= '0;
        ent_data[e] <= '0;
      end
    end else begin
      if (pop) begin
        ent_vld[head] <= 1'b0;
        head          <= head + ONE_PTR;
      end
      if (push) begin
        ent_rd[tail]   <= bus.wb_rd;
        ent_data[tail] <= bus.wb_data;
        ent_vld[tail]  <= 1'b1;
        tail           <= tail + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end

  // Pending-write scoreboard: OR of the destination decode of every valid
  // entry. x0 is forced clear since it is never a real hazard.
  always_comb begin
    pending = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_vld[e]) begin
        pending[ent_rd[e]] = 1'b1;
      end
    end
    pending[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: self-checking bench for regfile_writeback.
//
// Purpose:
//   Drives directed sequences and a randomized stretch of writeback traffic,
//   and compares every output each cycle against a queue-based model of the
//   writeback buffer kept in the bench.
//
// Ports: none (top-level bench).
module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(NREG);
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic            clk;
  logic            rst_n;
  logic [NREG-1:0] pending;
  logic [CW-1:0]   count;

  int total;
  int bad;

  wr_t model_q[$];

  regfile_writeback_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_writeback #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .pending (pending),
    .count   (count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected pending vector: one bit per destination still sitting in the queue.
  function automatic logic [NREG-1:0] modelPending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (model_q[i]) p[model_q[i].rd] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // Compare all DUT outputs against the model's current queue contents.
  task automatic checkAll(input string tag);
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [XLEN-1:0] exp_data;
    exp_we   = (model_q.size() != 0);
    exp_addr = exp_we ? model_q[0].rd   : '0;
    exp_data = exp_we ? model_q[0].data : '0;
    checkOutput({tag, ".we"},      64'(bus.rf_we),    64'(exp_we));
    checkOutput({tag, ".waddr"},   64'(bus.rf_waddr), 64'(exp_addr));
    checkOutput({tag, ".wdata"},   64'(bus.rf_wdata), 64'(exp_data));
    checkOutput({tag, ".count"},   64'(count),        64'(model_q.size()));
    checkOutput({tag, ".ready"},   64'(bus.wb_ready), 64'(model_q.size() < DEPTH));
    checkOutput({tag, ".pending"}, 64'(pending),      64'(modelPending()));
  endtask

  // One clock of traffic: drive inputs after the falling edge, check the
  // outputs of the current state, advance the model by what the next rising
  // edge will do, then return just after that edge with the request idle.
  task automatic applyStimulus(input string tag, input logic valid, input logic [AW-1:0] rd,
                               input logic [XLEN-1:0] data, input logic rfready);
    bit accept;
    bit do_pop;
    @(negedge clk);
    bus.wb_valid = valid;
    bus.wb_rd    = rd;
    bus.wb_data  = data;
    bus.rf_ready = rfready;
    #1;
    checkAll(tag);
    accept = valid && (model_q.size() < DEPTH);
    do_pop = (model_q.size() != 0) && rfready;
    if (do_pop) void'(model_q.pop_front());
    if (accept && rd != '0) model_q.push_back('{rd: rd, data: data});
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.rf_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.we",      64'(bus.rf_we),    64'd0);
    checkOutput("rst.count",   64'(count),        64'd0);
    checkOutput("rst.ready",   64'(bus.wb_ready), 64'd1);
    checkOutput("rst.pending", 64'(pending),      64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write lands the cycle after acceptance and drains.
    applyStimulus("t1.push", 1'b1, 5'd2, 32'hDEAD_BEEF, 1'b1);
    checkOutput("t1.we",      64'(bus.rf_we),    64'd1);
    checkOutput("t1.waddr",   64'(bus.rf_waddr), 64'd2);
    checkOutput("t1.wdata",   64'(bus.rf_wdata), 64'hDEAD_BEEF);
    checkOutput("t1.pending", 64'(pending),      64'h4);
    applyStimulus("t1.drain", 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("t1.count0",  64'(count),        64'd0);
    checkOutput("t1.pend0",   64'(pending),      64'd0);

    // x0 writes are swallowed.
    applyStimulus("t2.push", 1'b1, 5'd0, 32'h1234, 1'b1);
    checkOutput("t2.we",    64'(bus.rf_we), 64'd0);
    checkOutput("t2.count", 64'(count),     64'd0);

    // Fill with the port stalled, hold a fifth request, then release.
    for (int i = 1; i <= 4; i++)
      applyStimulus("t3.fill", 1'b1, AW'(i), XLEN'(i * 11), 1'b0);
    checkOutput("t3.count",   64'(count),        64'd4);
    checkOutput("t3.ready",   64'(bus.wb_ready), 64'd0);
    checkOutput("t3.pending", 64'(pending),      64'h1E);
    applyStimulus("t3.hold", 1'b1, 5'd7, 32'h77, 1'b0);
    checkOutput("t3.heldcnt", 64'(count), 64'd4);
    for (int i = 0; i < 6; i++)
      applyStimulus("t3.drain", 1'b1, 5'd7, 32'h77, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus("t3.idle", 1'b0, 5'd0, 32'h0, 1'b1);

    // Simultaneous push and pop at count=2, then run well past pointer wrap.
    applyStimulus("t4.a", 1'b1, 5'd8, 32'h80, 1'b0);
    applyStimulus("t4.b", 1'b1, 5'd10, 32'hA0, 1'b0);
    applyStimulus("t4.pp", 1'b1, 5'd9, 32'h90, 1'b1);
    checkOutput("t4.count",   64'(count),        64'd2);
    checkOutput("t4.waddr",   64'(bus.rf_waddr), 64'd10);
    for (int i = 0; i < 3 * DEPTH; i++)
      applyStimulus("t4.wrap", 1'b1, AW'(i + 11), 32'hC000_0000 + XLEN'(i), 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus("t4.idle", 1'b0, 5'd0, 32'h0, 1'b1);

    // Two writes to the same register keep pending set until the last pops.
    applyStimulus("t5.a", 1'b1, 5'd5, 32'hAAAA, 1'b0);
    applyStimulus("t5.b", 1'b1, 5'd5, 32'hBBBB, 1'b0);
    checkOutput("t5.pend5", 64'(pending[5]), 64'd1);
    applyStimulus("t5.pop1", 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("t5.pend5b", 64'(pending[5]),    64'd1);
    checkOutput("t5.wdataB", 64'(bus.rf_wdata),  64'hBBBB);
    applyStimulus("t5.pop2", 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput("t5.pend5c", 64'(pending[5]), 64'd0);

    // Reset in the middle of a cycle with writes queued.
    for (int i = 0; i < 3; i++)
      applyStimulus("t6.fill", 1'b1, AW'(i + 20), XLEN'(i + 100), 1'b0);
    #2;
    rst_n = 1'b0;
    model_q.delete();
    #1;
    checkOutput("t6.we",      64'(bus.rf_we),    64'd0);
    checkOutput("t6.count",   64'(count),        64'd0);
    checkOutput("t6.pending", 64'(pending),      64'd0);
    checkOutput("t6.waddr",   64'(bus.rf_waddr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus("t6.post", 1'b0, 5'd0, 32'h0, 1'b1);

    // Randomized traffic with random stalls on the write port.
    for (int i = 0; i < 400; i++) begin
      logic v;
      logic rr;
      logic [AW-1:0] r;
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 7));
      applyStimulus("rnd", v, r, XLEN'($urandom), rr);
    end
    for (int i = 0; i < DEPTH + 2; i++)
      applyStimulus("rnd.drain", 1'b0, 5'd0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
